// File: rtl/dm_pkg.sv
// Debug-module DMI types shared by the DTM-side request/response stages.
package dm;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  localparam int unsigned DmiMaxOutstandingDefault = 32'd1;

endpackage

// File: rtl/dmi_skid_buf.sv
// Generic 2-entry skid buffer; in_ready_o depends only on the state register.
module dmi_skid_buf
  import dm::*;
#(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  T     in_data_i,
  input  logic in_valid_i,
  output logic in_ready_o,
  output T     out_data_o,
  output logic out_valid_o,
  input  logic out_ready_i
);

  skid_state_e state_q, state_d;
  T            head_q, head_d;
  T            skid_q, skid_d;
  logic        push_s, pop_s;

  assign in_ready_o  = (state_q != SKID_TWO);
  assign out_valid_o = (state_q != SKID_EMPTY);
  assign out_data_o  = head_q;
  assign push_s      = in_valid_i & in_ready_o;
  assign pop_s       = out_valid_o & out_ready_i;

  // State, head and skid registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SKID_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  // Occupancy transitions; head always holds the oldest entry.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (push_s) begin
          state_d = SKID_ONE;
          head_d  = in_data_i;
        end else begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_ONE: begin
        if (push_s && pop_s) begin
          head_d = in_data_i;
        end else if (push_s) begin
          state_d = SKID_TWO;
          skid_d  = in_data_i;
        end else if (pop_s) begin
          state_d = SKID_EMPTY;
        end else begin
          state_d = SKID_ONE;
        end
      end
      SKID_TWO: begin
        if (pop_s) begin
          state_d = SKID_ONE;
          head_d  = skid_q;
        end else begin
          state_d = SKID_TWO;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

endmodule

// File: rtl/cdc_stage_req.sv
// TCK-domain DMI request stage: skid buffer plus in-flight credit limit and
// sticky detection of responses that arrive with nothing outstanding.
module cdc_stage_req
  import dm::*;
#(
  parameter  int unsigned MaxOutstanding = DmiMaxOutstandingDefault,
  localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic            tck_i,
  input  logic            trst_i,
  input  dmi_req_t        dmi_req_i,
  input  logic            dmi_req_valid_i,
  output logic            dmi_req_ready_o,
  output dmi_req_t        dmi_req_o,
  output logic            dmi_req_valid_o,
  input  logic            dmi_req_ready_i,
  input  logic            dmi_resp_valid_i,
  input  logic            dmi_resp_ready_i,
  output logic [CntW-1:0] outstanding_o,
  output logic            idle_o,
  output logic            err_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            buf_valid_s, credit_ok_s, pop_s, rsp_s;

  dmi_skid_buf #(.T(dmi_req_t)) u_buf (
    .clk_i      (tck_i),
    .rst_i      (trst_i),
    .in_data_i  (dmi_req_i),
    .in_valid_i (dmi_req_valid_i),
    .in_ready_o (dmi_req_ready_o),
    .out_data_o (dmi_req_o),
    .out_valid_o(buf_valid_s),
    .out_ready_i(dmi_req_ready_i & credit_ok_s)
  );

  // Valid is gated by credit; the count only rises on pop, so valid never drops early.
  assign credit_ok_s     = (cnt_q < CntW'(MaxOutstanding));
  assign dmi_req_valid_o = buf_valid_s & credit_ok_s;
  assign pop_s           = dmi_req_valid_o & dmi_req_ready_i;
  assign rsp_s           = dmi_resp_valid_i & dmi_resp_ready_i;
  assign outstanding_o   = cnt_q;
  assign err_o           = err_q;
  assign idle_o          = ~buf_valid_s & (cnt_q == '0);

  // Credit counter and sticky error registers.
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // A pop and a response in the same cycle cancel, even at zero count.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (pop_s && !rsp_s) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (rsp_s && !pop_s) begin
      if (cnt_q == '0) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

endmodule

// File: tb/tb_cdc_stage_req.sv
// Bench for cdc_stage_req: two instances (limits 1 and 4) on shared stimulus.
module tb_cdc_stage_req;
  import dm::*;

  logic     tck = 1'b0;
  logic     trst;
  dmi_req_t req_i;
  logic     vin, rdy, rv, rr;

  logic r1, v1, idle1, err1;
  dmi_req_t q1;
  logic [0:0] o1;
  logic r4, v4, idle4, err4;
  dmi_req_t q4;
  logic [2:0] o4;

  int total = 0;
  int bad = 0;

  always #5 tck = ~tck;

  cdc_stage_req #(.MaxOutstanding(1)) u1 (
    .tck_i(tck), .trst_i(trst), .dmi_req_i(req_i), .dmi_req_valid_i(vin),
    .dmi_req_ready_o(r1), .dmi_req_o(q1), .dmi_req_valid_o(v1),
    .dmi_req_ready_i(rdy), .dmi_resp_valid_i(rv), .dmi_resp_ready_i(rr),
    .outstanding_o(o1), .idle_o(idle1), .err_o(err1)
  );

  cdc_stage_req #(.MaxOutstanding(4)) u4 (
    .tck_i(tck), .trst_i(trst), .dmi_req_i(req_i), .dmi_req_valid_i(vin),
    .dmi_req_ready_o(r4), .dmi_req_o(q4), .dmi_req_valid_o(v4),
    .dmi_req_ready_i(rdy), .dmi_resp_valid_i(rv), .dmi_resp_ready_i(rr),
    .outstanding_o(o4), .idle_o(idle4), .err_o(err4)
  );

  typedef struct {
    logic        vin;
    dmi_req_t    req;
    logic        rdy;
    logic        rsp;
    logic        ev;
    logic        er;
    logic [2:0]  eo;
    logic        eidle;
    logic        chkd;
    dmi_req_t    ereq;
  } vec_t;

  vec_t tbl[8];

  // reference model state, index 0 -> limit 1, index 1 -> limit 4
  dmi_req_t mq[2][2];
  int       mn[2];
  int       mc[2];
  logic     me[2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic dmi_req_t mk(input logic [6:0] a, input dtm_op_e op, input logic [31:0] d);
    dmi_req_t r;
    r.addr = a;
    r.op   = op;
    r.data = d;
    return r;
  endfunction

  function automatic vec_t mkv(input logic vi, input dmi_req_t rq, input logic ry, input logic rs,
                               input logic ev, input logic er, input logic [2:0] eo,
                               input logic ei, input logic cd, input dmi_req_t eq);
    vec_t x;
    x.vin = vi; x.req = rq; x.rdy = ry; x.rsp = rs;
    x.ev = ev; x.er = er; x.eo = eo; x.eidle = ei; x.chkd = cd; x.ereq = eq;
    return x;
  endfunction

  // drive one cycle's inputs at the falling edge, then settle
  task automatic cyc_in(input logic vi, input dmi_req_t rq, input logic ry, input logic rs);
    @(negedge tck);
    vin = vi; req_i = rq; rdy = ry; rv = rs; rr = rs;
    #1;
  endtask

  task automatic do_reset();
    @(negedge tck);
    trst = 1'b1; vin = 1'b0; rdy = 1'b0; rv = 1'b0; rr = 1'b0; req_i = '0;
    @(negedge tck);
    trst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mn[k] = 0; mc[k] = 0; me[k] = 1'b0;
    end
  endtask

  initial begin
    dmi_req_t z;
    z = '0;
    trst = 1'b1; vin = 1'b0; rdy = 1'b0; rv = 1'b0; rr = 1'b0; req_i = '0;

    // reset values while trst_i is held
    repeat (2) @(posedge tck);
    #1;
    chk("rst_valid", 64'(v1), 64'(0));
    chk("rst_ready", 64'(r1), 64'(1));
    chk("rst_data", 64'(q1), 64'(0));
    chk("rst_out", 64'(o4), 64'(0));
    chk("rst_idle", 64'(idle4), 64'(1));
    chk("rst_err", 64'(err4), 64'(0));
    do_reset();

    // reset mid-stream with two entries buffered and one outstanding
    cyc_in(1'b1, mk(7'h01, DTM_READ, 32'h1), 1'b1, 1'b0);
    cyc_in(1'b1, mk(7'h02, DTM_READ, 32'h2), 1'b1, 1'b0);
    cyc_in(1'b1, mk(7'h03, DTM_WRITE, 32'h3), 1'b0, 1'b0);
    cyc_in(1'b0, z, 1'b0, 1'b0);
    chk("mid_ready1", 64'(r1), 64'(0));
    chk("mid_valid1", 64'(v1), 64'(0));
    chk("mid_out1", 64'(o1), 64'(1));
    chk("mid_valid4", 64'(v4), 64'(1));
    @(negedge tck);
    trst = 1'b1; vin = 1'b1; rdy = 1'b1;
    #1;
    chk("mrst_valid", 64'(v1), 64'(0));
    chk("mrst_ready", 64'(r1), 64'(1));
    chk("mrst_out", 64'(o1), 64'(0));
    chk("mrst_idle", 64'(idle1), 64'(1));
    chk("mrst_err", 64'(err1), 64'(0));
    chk("mrst_data", 64'(q1), 64'(0));
    @(negedge tck);
    trst = 1'b0; vin = 1'b0; rdy = 1'b0;
    @(negedge tck);
    #1;
    chk("prst_valid", 64'(v4), 64'(0));
    chk("prst_ready", 64'(r4), 64'(1));
    chk("prst_idle", 64'(idle4), 64'(1));
    chk("prst_out", 64'(o4), 64'(0));
    do_reset();

    // back-to-back with limit 4, one response per cycle after the first pop
    for (int c = 0; c < 10; c++) begin
      cyc_in(c < 8, mk(7'(8'h10 + c), DTM_READ, 32'(c)), 1'b1, (c >= 2) && (c <= 9));
      chk("b2b_ready", 64'(r4), 64'(1));
      chk("b2b_out", 64'(o4), (c >= 2) ? 64'(1) : 64'(0));
      chk("b2b_valid", 64'(v4), ((c >= 1) && (c <= 8)) ? 64'(1) : 64'(0));
      if ((c >= 1) && (c <= 8)) chk("b2b_addr", 64'(q4.addr), 64'(8'h10 + c - 1));
    end
    cyc_in(1'b0, z, 1'b0, 1'b0);
    chk("b2b_end_out", 64'(o4), 64'(0));
    chk("b2b_end_idle", 64'(idle4), 64'(1));
    chk("b2b_end_err", 64'(err4), 64'(0));
    do_reset();

    // backpressure table on the limit-4 instance
    tbl[0] = mkv(1'b1, mk(7'h04, DTM_READ, 32'h0), 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, z);
    tbl[1] = mkv(1'b1, mk(7'h05, DTM_WRITE, 32'hDEADBEEF), 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, mk(7'h04, DTM_READ, 32'h0));
    tbl[2] = mkv(1'b0, z, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, mk(7'h04, DTM_READ, 32'h0));
    tbl[3] = mkv(1'b0, z, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, mk(7'h04, DTM_READ, 32'h0));
    tbl[4] = mkv(1'b0, z, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, mk(7'h05, DTM_WRITE, 32'hDEADBEEF));
    tbl[5] = mkv(1'b0, z, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, z);
    tbl[6] = mkv(1'b0, z, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, z);
    tbl[7] = mkv(1'b0, z, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, z);
    for (int i = 0; i < 8; i++) begin
      cyc_in(tbl[i].vin, tbl[i].req, tbl[i].rdy, tbl[i].rsp);
      chk($sformatf("bp%0d_valid", i), 64'(v4), 64'(tbl[i].ev));
      chk($sformatf("bp%0d_ready", i), 64'(r4), 64'(tbl[i].er));
      chk($sformatf("bp%0d_out", i), 64'(o4), 64'(tbl[i].eo));
      chk($sformatf("bp%0d_idle", i), 64'(idle4), 64'(tbl[i].eidle));
      if (tbl[i].chkd) chk($sformatf("bp%0d_req", i), 64'(q4), 64'(tbl[i].ereq));
    end
    do_reset();

    // credit stall (limit 1), simultaneous pop+rsp (limit 4), spurious response
    cyc_in(1'b1, mk(7'h11, DTM_READ, 32'h0), 1'b1, 1'b0);
    cyc_in(1'b1, mk(7'h12, DTM_READ, 32'h0), 1'b1, 1'b0);
    chk("cs_valid_a", 64'(v1), 64'(1));
    chk("cs_addr_a", 64'(q1.addr), 64'(7'h11));
    cyc_in(1'b0, z, 1'b1, 1'b1);
    chk("cs_valid_b", 64'(v1), 64'(0));
    chk("cs_out_b", 64'(o1), 64'(1));
    chk("cs_addr_b", 64'(q1.addr), 64'(7'h12));
    chk("sim_valid4", 64'(v4), 64'(1));
    cyc_in(1'b0, z, 1'b1, 1'b0);
    chk("cs_valid_c", 64'(v1), 64'(1));
    chk("cs_out_c", 64'(o1), 64'(0));
    chk("sim_out4", 64'(o4), 64'(1));
    chk("sim_err4", 64'(err4), 64'(0));
    cyc_in(1'b0, z, 1'b1, 1'b1);
    chk("cs_valid_d", 64'(v1), 64'(0));
    chk("cs_out_d", 64'(o1), 64'(1));
    chk("cs_idle_d", 64'(idle1), 64'(0));
    cyc_in(1'b0, z, 1'b1, 1'b1);
    chk("sp_out1", 64'(o1), 64'(0));
    chk("sp_err_pre", 64'(err1), 64'(0));
    for (int i = 0; i < 4; i++) begin
      cyc_in(1'b1, mk(7'(8'h20 + i), DTM_WRITE, 32'(i)), 1'b1, 1'b0);
      chk("sp_err1", 64'(err1), 64'(1));
      chk("sp_err4", 64'(err4), 64'(1));
      if (i == 0) chk("sp_out_zero", 64'(o1), 64'(0));
    end
    do_reset();
    #1;
    chk("sp_err_cleared", 64'(err1), 64'(0));

    // randomized traffic against the queue-level reference model
    for (int c = 0; c < 3000; c++) begin
      dmi_req_t rq;
      logic rs_v, rs_r;
      rq.addr = 7'($urandom);
      rq.op   = dtm_op_e'($urandom_range(0, 2));
      rq.data = $urandom;
      rs_v = ($urandom_range(0, 4) == 0);
      rs_r = ($urandom_range(0, 1) == 1);
      @(negedge tck);
      vin = ($urandom_range(0, 2) != 0); req_i = rq;
      rdy = ($urandom_range(0, 3) != 0); rv = rs_v; rr = rs_r;
      #1;
      for (int k = 0; k < 2; k++) begin
        int mo;
        logic ev, er, push, pop, rsp;
        logic av, ar, ai, ae;
        int ao;
        dmi_req_t aq;
        mo = (k == 0) ? 1 : 4;
        av = (k == 0) ? v1 : v4;
        ar = (k == 0) ? r1 : r4;
        ai = (k == 0) ? idle1 : idle4;
        ae = (k == 0) ? err1 : err4;
        ao = (k == 0) ? int'(o1) : int'(o4);
        aq = (k == 0) ? q1 : q4;
        er = (mn[k] < 2);
        ev = (mn[k] > 0) && (mc[k] < mo);
        chk($sformatf("rnd%0d_valid", k), 64'(av), 64'(ev));
        chk($sformatf("rnd%0d_ready", k), 64'(ar), 64'(er));
        chk($sformatf("rnd%0d_out", k), 64'(ao), 64'(mc[k]));
        chk($sformatf("rnd%0d_idle", k), 64'(ai), 64'((mn[k] == 0) && (mc[k] == 0)));
        chk($sformatf("rnd%0d_err", k), 64'(ae), 64'(me[k]));
        if (mn[k] > 0) chk($sformatf("rnd%0d_req", k), 64'(aq), 64'(mq[k][0]));
        push = vin & er;
        pop  = ev & rdy;
        rsp  = rv & rr;
        if (pop) begin
          mq[k][0] = mq[k][1];
          mn[k]--;
        end
        if (push) begin
          mq[k][mn[k]] = req_i;
          mn[k]++;
        end
        if (pop && !rsp) mc[k]++;
        else if (rsp && !pop) begin
          if (mc[k] == 0) me[k] = 1'b1;
          else mc[k]--;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
